// File: rtl/gfx_line_stream.sv
// Bresenham line rasteriser: accepts one line command, walks every pixel top-to-bottom,
// and emits the unmasked ones over a ready/valid pixel stream with a last-pixel flag.
module gfx_line_stream #(
    parameter  int FB_WIDTH     = 640,
    parameter  int FB_HEIGHT    = 480,
    parameter  int PATTERN_BITS = 16,
    localparam int X_BITS       = $clog2(FB_WIDTH),
    localparam int Y_BITS       = $clog2(FB_HEIGHT),
    localparam int C_BITS       = (X_BITS > Y_BITS) ? X_BITS : Y_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [X_BITS-1:0]       cmd_x0,
    input  logic [Y_BITS-1:0]       cmd_y0,
    input  logic [X_BITS-1:0]       cmd_x1,
    input  logic [Y_BITS-1:0]       cmd_y1,
    input  logic [PATTERN_BITS-1:0] cmd_pattern,
    input  logic                    abort,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [X_BITS-1:0]       pix_x,
    output logic [Y_BITS-1:0]       pix_y,
    output logic                    pix_last,
    output logic                    busy,
    output logic                    done
);
    localparam int CW = C_BITS + 2;
    localparam logic signed [CW-1:0] ERR_ZERO = '0;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_DELTA, S_SETUP, S_DRAW} state_t;

    state_t                   state, state_nxt;
    logic [X_BITS-1:0]        xa, xb, x;
    logic [Y_BITS-1:0]        ya, yb, y;
    logic [PATTERN_BITS-1:0]  pat_l, pat;
    logic                     ltr;
    logic signed [CW-1:0]     dx, dy, err, err_step;
    logic signed [CW:0]       e2;
    logic [X_BITS-1:0]        xdiff;
    logic                     step, at_end, movx, movy;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign pix_x     = x;
    assign pix_y     = y;
    assign at_end    = (x == xb) && (y == yb);
    assign pix_valid = (state == S_DRAW) && pat[0];
    assign pix_last  = (state == S_DRAW) && at_end;
    assign xdiff     = ltr ? (xb - xa) : (xa - xb);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        e2        = {err, 1'b0};
        movx      = (e2 >= $signed({dy[CW-1], dy}));
        movy      = (e2 <= $signed({dx[CW-1], dx}));
        err_step  = err + (movx ? dy : ERR_ZERO) + (movy ? dx : ERR_ZERO);
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_NORM;
            S_NORM:  state_nxt = S_DELTA;
            S_DELTA: state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_DRAW;
            S_DRAW: begin
                // Masked pixels advance unconditionally; emitted ones wait for the handshake.
                step = !pat[0] || pix_ready;
                if (step && at_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xa    <= '0;
            xb    <= '0;
            ya    <= '0;
            yb    <= '0;
            x     <= '0;
            y     <= '0;
            pat_l <= '0;
            pat   <= '0;
            ltr   <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                case (state)
                    S_IDLE: if (cmd_valid) begin
                        xa    <= cmd_x0;
                        ya    <= cmd_y0;
                        xb    <= cmd_x1;
                        yb    <= cmd_y1;
                        pat_l <= cmd_pattern;
                    end
                    S_NORM: begin
                        // Always walk downwards so y only ever increments.
                        if (ya > yb) begin
                            xa  <= xb;
                            xb  <= xa;
                            ya  <= yb;
                            yb  <= ya;
                            ltr <= (xb < xa);
                        end else begin
                            ltr <= (xa < xb);
                        end
                    end
                    S_DELTA: begin
                        dx <= $signed({{(CW-X_BITS){1'b0}}, xdiff});
                        dy <= $signed({{(CW-Y_BITS){1'b0}}, ya}) - $signed({{(CW-Y_BITS){1'b0}}, yb});
                    end
                    S_SETUP: begin
                        err <= dx + dy;
                        x   <= xa;
                        y   <= ya;
                        pat <= pat_l;
                    end
                    S_DRAW: if (step) begin
                        pat <= {pat[0], pat[PATTERN_BITS-1:1]};
                        if (at_end) begin
                            done <= 1'b1;
                        end else begin
                            if (movx) x <= ltr ? x + X_BITS'(1) : x - X_BITS'(1);
                            if (movy) y <= y + Y_BITS'(1);
                            err <= err_step;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gfx_line_stream.sv
// Directed bench for gfx_line_stream: hand-computed pixel sequences, stall, dash, abort, reset.
module tb_gfx_line_stream;
    localparam int XB = 10;
    localparam int YB = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          abort = 1'b0;
    logic          pix_ready = 1'b1;
    logic [XB-1:0] cmd_x0 = '0, cmd_x1 = '0;
    logic [YB-1:0] cmd_y0 = '0, cmd_y1 = '0;
    logic [15:0]   cmd_pattern = '0;
    logic          cmd_ready, pix_valid, pix_last, busy, done;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;

    gfx_line_stream dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_pattern(cmd_pattern), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int xy(input int x, input int y);
        return x * 1000 + y;
    endfunction

    int exp_q[$];
    int got_q[$];
    bit got_last[$];
    int first_lat, done_cyc, stall_bad;
    bit finished;

    int exp_swap [9] = '{1001, 2002, 2003, 3004, 3005, 4006, 4007, 5008, 5009};
    int exp_stall[4] = '{0, 1000, 2001, 3001};
    int exp_rtol [5] = '{6002, 5003, 4003, 3004, 2004};

    task automatic run_line(input string tag, input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] pat, input bit toggle);
        int k;
        bit stalled;
        int sx, sy;
        got_q.delete();
        got_last.delete();
        first_lat = -1; done_cyc = -1; stall_bad = 0; finished = 0;
        stalled = 0; sx = 0; sy = 0;
        @(negedge clk);
        cmd_x0 = x0[XB-1:0]; cmd_y0 = y0[YB-1:0];
        cmd_x1 = x1[XB-1:0]; cmd_y1 = y1[YB-1:0];
        cmd_pattern = pat; cmd_valid = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        while (k < 300 && !finished) begin
            pix_ready = toggle ? k[0] : 1'b1;
            if (stalled && (!pix_valid || int'(pix_x) != sx || int'(pix_y) != sy)) stall_bad++;
            if (pix_valid && first_lat < 0) first_lat = k;
            if (done) begin
                done_cyc = k;
                finished = 1;
            end
            if (pix_valid && pix_ready) begin
                got_q.push_back(xy(int'(pix_x), int'(pix_y)));
                got_last.push_back(pix_last);
            end
            stalled = pix_valid && !pix_ready;
            sx = int'(pix_x);
            sy = int'(pix_y);
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_timeout"}, finished, 1);
        pix_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, cmd_ready, 1);
    endtask

    task automatic compare_line(input string tag, input bit last_emitted, input int exp_done);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], (last_emitted && i == exp_q.size() - 1));
        end
        check({tag, "_latency"}, first_lat, 4);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_stall"}, stall_bad, 0);
    endtask

    initial begin
        int d;
        #12;
        check("rst_valid", pix_valid, 0);
        check("rst_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Abort after the 2nd pixel of (0,0)->(9,0); a stray command mid-line is ignored.
        @(negedge clk);
        cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 9; cmd_y1 = 0; cmd_pattern = 16'hFFFF;
        cmd_valid = 1'b1; pix_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        cmd_x0 = 50; cmd_y0 = 50; cmd_x1 = 60; cmd_y1 = 60; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_pre_x", pix_x, 2);
        check("abort_pre_y", pix_y, 0);
        check("abort_pre_valid", pix_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", pix_valid, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        d = 0;
        repeat (4) begin
            d = d | int'(done);
            @(negedge clk);
        end
        check("abort_no_done", d, 0);

        // Abort in the same cycle as a command blocks the accept.
        cmd_x0 = 1; cmd_y0 = 1; cmd_x1 = 3; cmd_y1 = 3; cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        check("abort_accept_busy", busy, 0);

        exp_q.delete();
        for (int i = 2; i <= 6; i++) exp_q.push_back(xy(i, 3));
        run_line("horiz", 2, 3, 6, 3, 16'hFFFF, 0);
        compare_line("horiz", 1, 9);

        exp_q.delete();
        foreach (exp_swap[i]) exp_q.push_back(exp_swap[i]);
        run_line("swap", 5, 9, 1, 1, 16'hFFFF, 0);
        compare_line("swap", 1, 13);
        run_line("fwd", 1, 1, 5, 9, 16'hFFFF, 0);
        compare_line("fwd", 1, 13);

        exp_q.delete();
        for (int i = 0; i <= 6; i += 2) exp_q.push_back(xy(i, i));
        run_line("dash", 0, 0, 7, 7, 16'h5555, 0);
        compare_line("dash", 0, 12);

        exp_q.delete();
        foreach (exp_stall[i]) exp_q.push_back(exp_stall[i]);
        run_line("stall", 0, 0, 3, 1, 16'hFFFF, 1);
        compare_line("stall", 1, 12);

        exp_q.delete();
        exp_q.push_back(xy(10, 10));
        run_line("single", 10, 10, 10, 10, 16'hFFFF, 0);
        compare_line("single", 1, 5);

        exp_q.delete();
        foreach (exp_rtol[i]) exp_q.push_back(exp_rtol[i]);
        run_line("rtol", 6, 2, 2, 4, 16'hFFFF, 0);
        compare_line("rtol", 1, 9);

        exp_q.delete();
        for (int i = 2; i <= 5; i++) exp_q.push_back(xy(4, i));
        run_line("vert", 4, 2, 4, 5, 16'hFFFF, 0);
        compare_line("vert", 1, 8);

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 9; cmd_y1 = 0; cmd_pattern = 16'hFFFF;
        cmd_valid = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_pre_x", pix_x, 3);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_x", pix_x, 0);
        check("rstmid_y", pix_y, 0);
        check("rstmid_valid", pix_valid, 0);
        check("rstmid_last", pix_last, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstmid_after_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
